// File: rtl/zion_basic_circuit_lib_skid_reg.sv
// Two-entry valid/ready skid register.
// oVld, oRdy and oCnt depend on registered state only, so back-pressure is cut.
module zion_basic_circuit_lib_skid_reg #(
  parameter int unsigned          WIDTH    = 8,
  parameter logic [WIDTH-1:0]     INI_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iClr,
  input  logic             iVld,
  output logic             oRdy,
  input  logic [WIDTH-1:0] iDat,
  output logic             oVld,
  input  logic             iRdy,
  output logic [WIDTH-1:0] oDat,
  output logic [1:0]       oCnt
);

  if (WIDTH < 1) begin : g_chk
`ifdef CHECK_ERR_EXIT
    $fatal(1, "skid_reg: WIDTH must be >= 1");
`else
    $error("skid_reg: WIDTH must be >= 1");
`endif
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             inF, outF;

  always_comb begin
    oVld = 1'b0;
    oRdy = 1'b0;
    oCnt = 2'd0;
    case (state_q)
      EMPTY: begin
        oRdy = 1'b1;
      end
      BUSY: begin
        oVld = 1'b1;
        oRdy = 1'b1;
        oCnt = 2'd1;
      end
      FULL: begin
        oVld = 1'b1;
        oCnt = 2'd2;
      end
      default: begin
        oVld = 1'b0;
      end
    endcase
  end

  assign inF  = iVld & oRdy;
  assign outF = oVld & iRdy;
  assign oDat = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (inF) begin
          state_d = BUSY;
          main_d  = iDat;
        end
      end
      BUSY: begin
        if (inF && outF) begin
          main_d = iDat;
        end else if (inF) begin
          state_d = FULL;
          skid_d  = iDat;
        end else if (outF) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (outF) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    // Clear wins over any transfer seen in the same cycle.
    if (iClr) begin
      state_d = EMPTY;
      main_d  = INI_DATA;
      skid_d  = INI_DATA;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= INI_DATA;
      skid_q  <= INI_DATA;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: doc/zion_basic_circuit_lib_skid_reg.md
# zion_basic_circuit_lib_skid_reg

Two-entry valid/ready pipeline register (skid buffer) for the basic circuit library. It registers a data stream between a producer and a consumer at full throughput. Both `oVld` and `oRdy` are registered, so there is no combinational path from `iRdy` to `oRdy`. It is the handshaked stage placed directly downstream of plain enable-DFF datapaths when back-pressure must be cut for timing.

## Interface
Parameters:
- WIDTH, 8 — data width in bits; legal range 1..1024.
- INI_DATA, '0 — value loaded into both data registers on reset and on clear.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- iClr  input  1  synchronous clear, active high; dominates every other input.
- iVld  input  1  upstream data valid.
- oRdy  output  1  upstream ready; registered.
- iDat  input  WIDTH  upstream data.
- oVld  output  1  downstream data valid; registered.
- iRdy  input  1  downstream ready.
- oDat  output  WIDTH  downstream data; driven directly from the main register.
- oCnt  output  2  occupancy, 0..2.

## Operation
- Handshake definitions:
  - Input fire (inF) = iVld & oRdy.
  - Output fire (outF) = oVld & iRdy.
  - Standard AXI-style rules apply: once iVld is high, the producer holds iVld and iDat until it is accepted. The block holds oVld and oDat stable while oVld & !iRdy.
- Storage: main register (feeds oDat) and skid register.
- State machine:
  - EMPTY: oVld=0, oRdy=1, oCnt=0.
  - BUSY: oVld=1, oRdy=1, oCnt=1.
  - FULL: oVld=1, oRdy=0, oCnt=2.
- EMPTY transitions:
  - inF → BUSY; main ← iDat.
  - Otherwise hold.
- BUSY transitions:
  - inF & outF → BUSY; main ← iDat.
  - inF & !outF → FULL; skid ← iDat.
  - !inF & outF → EMPTY.
  - Otherwise hold.
- FULL transitions:
  - outF → BUSY; main ← skid.
  - Otherwise hold. No input is accepted because oRdy=0.
- Outputs: oVld, oRdy and oCnt are decoded from registered state only; no input feeds them combinationally.
- iClr=1: next state EMPTY, main and skid ← INI_DATA. An inF or outF in the same cycle is discarded; the output-side transfer already seen by the consumer is not undone.
- Unreachable state encodings recover to EMPTY on the next edge.
- The skid register is written only on the BUSY→FULL transition. Its content is don't-care outside FULL, but it is never X after reset.
- Parameter check at elaboration: WIDTH < 1 raises $error; with CHECK_ERR_EXIT defined, the check also calls $finish.

## Timing
- Reset (rst=0, asynchronous):
  - Values: state EMPTY, oVld=0, oRdy=1, oCnt=0, oDat=INI_DATA, skid=INI_DATA.
  - While rst=0, iVld is ignored.
  - First possible acceptance is the first rising edge with rst=1.
- rst asserted mid-operation drops all stored data immediately; no partial transfer completes.
- Latency: an input accepted at edge N appears on oDat with oVld=1 after edge N, i.e. 1 cycle.
- Throughput: 1 word per cycle sustained while iRdy=1. Occupancy stays at 1.
- Back-pressure: after iRdy falls, at most one additional word is absorbed (into skid). oRdy falls on the following edge.
- Recovery: from FULL, oRdy returns to 1 one edge after the first outF.
- Ordering: words leave strictly in acceptance order; no word is duplicated or lost except by iClr or rst.

## Test plan
- Reset check: hold rst=0 for 3 cycles with iVld=1, iDat=8'hAA → oVld=0, oRdy=1, oCnt=0, oDat=INI_DATA throughout. Release rst; the first accept happens at the next edge, and oDat=8'hAA one cycle later.
- Streaming: iRdy=1 constant; send 0x01..0x10 on consecutive cycles → the same sequence on oDat with 1-cycle latency, no bubbles, oCnt=1, oRdy never 0.
- Stall: in BUSY holding 0x05, drop iRdy while 0x06 and 0x07 are offered.
  - Accept 0x06 → FULL, oRdy=0, oCnt=2, 0x07 held upstream.
  - Raise iRdy → output 0x05, 0x06, 0x07 in order. oRdy returns to 1 one cycle after the first outF.
- Random: random iVld and iRdy (50%) over 10,000 cycles against a scoreboard.
  - Pass criteria: exact in-order match; oDat and oVld stable whenever oVld & !iRdy; oCnt equals scoreboard occupancy every cycle.
- Clear: in FULL (holding 0x11, 0x12), assert iClr with iVld=1, iDat=0x13, iRdy=1 → next cycle EMPTY, oVld=0, oDat=INI_DATA. No 0x12 or 0x13 is ever delivered.
- Async reset mid-stall: assert rst=0 between clock edges while FULL → oVld=0, oRdy=1, oCnt=0 immediately, without waiting for a clock edge.
